// File: rtl/mem_responder.sv
// mem_responder: word-addressed read responder with fixed response latency.
// A read is captured in IDLE or RESP, waits LATENCY cycles in WAIT, then
// presents a one-cycle valid strobe carrying the word (or an error flag).
// The storage array can be preloaded through the wr_* port in any state.
module mem_responder #(
    parameter int unsigned DEPTH   = 128,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        read,
    output logic [31:0] data,
    output logic        valid,
    output logic        err,
    output logic        busy,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
);

    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    cnt;
    logic [3:0]    cnt_nxt;
    logic          capture;
    logic [AW-1:0] cap_idx;
    logic          cap_err;
    logic [31:0]   data_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a < LIMIT);
    endfunction

    assign capture = (state != WAIT) && read;

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE, RESP: begin
                if (read) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Request capture: word index and range/alignment verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_idx <= '0;
            cap_err <= 1'b0;
        end else if (capture) begin
            cap_idx <= addr[AW+1:2];
            cap_err <= !in_range(addr);
        end
    end

    // Response register: array read at the edge entering RESP, so a write at
    // that same edge is not seen while any earlier write is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (state_nxt == RESP) begin
            data_q <= cap_err ? '0 : mem[cap_idx];
            err_q  <= cap_err;
        end else begin
            data_q <= '0;
            err_q  <= 1'b0;
        end
    end

    // Preload write port; misaligned or out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (wr_en && in_range(wr_addr)) begin
            mem[wr_addr[AW+1:2]] <= wr_data;
        end
    end

    assign valid = (state == RESP);
    assign busy  = (state == WAIT);
    assign data  = data_q;
    assign err   = err_q;

endmodule
